// File: rtl/midi_pkg.sv
// Shared MIDI definitions: parser state encoding, status constants and the
// data-length lookup used when a status byte opens a message.
package midi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_D1 = 2'd1,
        ST_WAIT_D2 = 2'd2,
        ST_SYSEX   = 2'd3
    } midi_state_t;

    localparam logic [7:0] MIDI_SYSEX_START = 8'hF0;
    localparam logic [7:0] MIDI_SYSEX_END   = 8'hF7;
    localparam logic [7:0] MIDI_TUNE_REQ    = 8'hF6;
    localparam logic [7:0] MIDI_RT_MIN      = 8'hF8;

    // Number of data bytes that follow a status byte (0 for non-status bytes).
    function automatic logic [1:0] midi_data_len(input logic [7:0] status);
        logic [1:0] len;
        len = 2'd0;
        if (status[7]) begin
            if (status < 8'hF0) begin
                len = (status[7:4] == 4'hC || status[7:4] == 4'hD) ? 2'd1 : 2'd2;
            end else begin
                case (status)
                    8'hF1, 8'hF3: len = 2'd1;
                    8'hF2:        len = 2'd2;
                    default:      len = 2'd0;
                endcase
            end
        end
        return len;
    endfunction

endpackage

// File: rtl/midi_msg_parser.sv
// Assembles MIDI channel/system-common messages from UART bytes with running
// status, realtime pass-through, sysex discard and a valid/ready output register.
module midi_msg_parser
    import midi_pkg::*;
#(
    parameter int RUNNING_STATUS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_data_rdy,
    output logic [7:0] msg_status,
    output logic [7:0] msg_data1,
    output logic [7:0] msg_data2,
    output logic [1:0] msg_len,
    output logic       msg_valid,
    input  logic       msg_ready,
    output logic [7:0] rt_byte,
    output logic       rt_valid,
    output logic       sysex_active,
    output logic       overrun
);

    midi_state_t state;
    logic        z_rdy;
    logic        byte_stb;
    logic [7:0]  run_status;
    logic        run_valid;
    logic [7:0]  cur_status;
    logic [7:0]  data1;
    logic [1:0]  need;
    logic        rs_en;

    logic        emit;
    logic [7:0]  e_status;
    logic [7:0]  e_d1;
    logic [7:0]  e_d2;
    logic [1:0]  e_len;

    assign byte_stb = rx_data_rdy & ~z_rdy;
    assign rs_en    = (RUNNING_STATUS != 0);

    // Decide whether the byte captured this cycle completes a message.
    always_comb begin
        emit     = 1'b0;
        e_status = cur_status;
        e_d1     = data1;
        e_d2     = 8'h00;
        e_len    = 2'd0;
        if (byte_stb) begin
            if (rx_data == MIDI_TUNE_REQ) begin
                emit     = 1'b1;
                e_status = MIDI_TUNE_REQ;
                e_d1     = 8'h00;
                e_len    = 2'd1;
            end else if (!rx_data[7]) begin
                case (state)
                    ST_IDLE: begin
                        if (rs_en && run_valid && midi_data_len(run_status) == 2'd1) begin
                            emit     = 1'b1;
                            e_status = run_status;
                            e_d1     = rx_data;
                            e_len    = 2'd2;
                        end
                    end
                    ST_WAIT_D1: begin
                        if (need == 2'd1) begin
                            emit  = 1'b1;
                            e_d1  = rx_data;
                            e_len = 2'd2;
                        end
                    end
                    ST_WAIT_D2: begin
                        emit  = 1'b1;
                        e_d2  = rx_data;
                        e_len = 2'd3;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= ST_IDLE;
            z_rdy        <= 1'b1;
            run_status   <= 8'h00;
            run_valid    <= 1'b0;
            cur_status   <= 8'h00;
            data1        <= 8'h00;
            need         <= 2'd0;
            msg_status   <= 8'h00;
            msg_data1    <= 8'h00;
            msg_data2    <= 8'h00;
            msg_len      <= 2'd0;
            msg_valid    <= 1'b0;
            rt_byte      <= 8'h00;
            rt_valid     <= 1'b0;
            sysex_active <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            z_rdy    <= rx_data_rdy;
            rt_valid <= 1'b0;
            overrun  <= 1'b0;

            if (emit) begin
                if (!msg_valid || msg_ready) begin
                    msg_status <= e_status;
                    msg_data1  <= e_d1;
                    msg_data2  <= e_d2;
                    msg_len    <= e_len;
                    msg_valid  <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (msg_valid && msg_ready) begin
                msg_valid <= 1'b0;
            end

            if (byte_stb) begin
                if (rx_data >= MIDI_RT_MIN) begin
                    rt_byte  <= rx_data;
                    rt_valid <= 1'b1;
                end else if (rx_data[7]) begin
                    // Any non-realtime status ends a sysex; F0 re-arms it below.
                    sysex_active <= 1'b0;
                    if (rx_data < 8'hF0) begin
                        run_status <= rx_data;
                        run_valid  <= 1'b1;
                        cur_status <= rx_data;
                        need       <= midi_data_len(rx_data);
                        state      <= ST_WAIT_D1;
                    end else begin
                        case (rx_data)
                            MIDI_SYSEX_START: begin
                                run_valid    <= 1'b0;
                                sysex_active <= 1'b1;
                                state        <= ST_SYSEX;
                            end
                            MIDI_SYSEX_END: begin
                                if (state == ST_SYSEX) state <= ST_IDLE;
                            end
                            8'hF1, 8'hF2, 8'hF3: begin
                                run_valid  <= 1'b0;
                                cur_status <= rx_data;
                                need       <= midi_data_len(rx_data);
                                state      <= ST_WAIT_D1;
                            end
                            default: begin
                                run_valid <= 1'b0;
                                state     <= ST_IDLE;
                            end
                        endcase
                    end
                end else begin
                    case (state)
                        ST_IDLE: begin
                            if (rs_en && run_valid) begin
                                cur_status <= run_status;
                                data1      <= rx_data;
                                need       <= midi_data_len(run_status);
                                if (midi_data_len(run_status) == 2'd2) state <= ST_WAIT_D2;
                            end
                        end
                        ST_WAIT_D1: begin
                            data1 <= rx_data;
                            state <= (need == 2'd2) ? ST_WAIT_D2 : ST_IDLE;
                        end
                        ST_WAIT_D2: state <= ST_IDLE;
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_midi_msg_parser.sv
// Directed bench for midi_msg_parser: byte sequences with hand-computed messages.
module tb_midi_msg_parser;

    logic       clk;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_data_rdy;
    logic [7:0] msg_status;
    logic [7:0] msg_data1;
    logic [7:0] msg_data2;
    logic [1:0] msg_len;
    logic       msg_valid;
    logic       msg_ready;
    logic [7:0] rt_byte;
    logic       rt_valid;
    logic       sysex_active;
    logic       overrun;

    int tests  = 0;
    int failed = 0;

    midi_msg_parser #(.RUNNING_STATUS(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_data_rdy  (rx_data_rdy),
        .msg_status   (msg_status),
        .msg_data1    (msg_data1),
        .msg_data2    (msg_data2),
        .msg_len      (msg_len),
        .msg_valid    (msg_valid),
        .msg_ready    (msg_ready),
        .rt_byte      (rt_byte),
        .rt_valid     (rt_valid),
        .sysex_active (sysex_active),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Lower rdy for a cycle, present the byte, and stop #1 after the capturing edge.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data_rdy = 1'b0;
        @(negedge clk);
        rx_data     = b;
        rx_data_rdy = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic check_msg(input string tag, input logic [7:0] s, input logic [7:0] d1,
                             input logic [7:0] d2, input logic [1:0] len);
        check({tag, ".valid"},  {31'd0, msg_valid}, 32'd1);
        check({tag, ".status"}, {24'd0, msg_status}, {24'd0, s});
        check({tag, ".d1"},     {24'd0, msg_data1}, {24'd0, d1});
        check({tag, ".d2"},     {24'd0, msg_data2}, {24'd0, d2});
        check({tag, ".len"},    {30'd0, msg_len},   {30'd0, len});
    endtask

    initial begin
        reset       = 1'b0;
        rx_data     = 8'h00;
        rx_data_rdy = 1'b0;
        msg_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst.valid",  {31'd0, msg_valid}, 32'd0);
        check("rst.len",    {30'd0, msg_len}, 32'd0);
        check("rst.status", {24'd0, msg_status}, 32'd0);
        check("rst.rt",     {31'd0, rt_valid}, 32'd0);
        check("rst.sysex",  {31'd0, sysex_active}, 32'd0);
        check("rst.ovr",    {31'd0, overrun}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Note-on, full three bytes
        send(8'h90); send(8'h3C);
        check("note.partial", {31'd0, msg_valid}, 32'd0);
        send(8'h64);
        check_msg("note", 8'h90, 8'h3C, 8'h64, 2'd3);

        // Running status reuses 90
        send(8'h40);
        check("rs.partial", {31'd0, msg_valid}, 32'd0);
        send(8'h00);
        check_msg("rs", 8'h90, 8'h40, 8'h00, 2'd3);

        // Realtime inside a program change
        send(8'hC5); send(8'hF8);
        check("rt.valid", {31'd0, rt_valid}, 32'd1);
        check("rt.byte",  {24'd0, rt_byte}, 32'hF8);
        check("rt.nomsg", {31'd0, msg_valid}, 32'd0);
        @(posedge clk); #1;
        check("rt.pulse", {31'd0, rt_valid}, 32'd0);
        send(8'h07);
        check_msg("pc", 8'hC5, 8'h07, 8'h00, 2'd2);
        send(8'h08);
        check_msg("pc.rs", 8'hC5, 8'h08, 8'h00, 2'd2);

        // Sysex is tracked and discarded; trailing data has no running status
        send(8'hF0);
        check("sx.active", {31'd0, sysex_active}, 32'd1);
        send(8'h7E); send(8'h01);
        check("sx.mid",    {31'd0, sysex_active}, 32'd1);
        check("sx.nomsg",  {31'd0, msg_valid}, 32'd0);
        send(8'hF7);
        check("sx.end",    {31'd0, sysex_active}, 32'd0);
        send(8'h40);
        check("sx.trail",  {31'd0, msg_valid}, 32'd0);

        // Sysex aborted by a channel status
        send(8'hF0); send(8'h11); send(8'h90);
        check("abort.sx", {31'd0, sysex_active}, 32'd0);
        send(8'h3C); send(8'h64);
        check_msg("abort", 8'h90, 8'h3C, 8'h64, 2'd3);

        // System common: tune request and song position
        send(8'hF6);
        check_msg("tune", 8'hF6, 8'h00, 8'h00, 2'd1);
        send(8'hF2); send(8'h10); send(8'h20);
        check_msg("spp", 8'hF2, 8'h10, 8'h20, 2'd3);
        send(8'h30);
        check("spp.norun", {31'd0, msg_valid}, 32'd0);

        // Backpressure: second message dropped with one overrun pulse
        msg_ready = 1'b0;
        send(8'hB0); send(8'h07); send(8'h7F);
        check_msg("held", 8'hB0, 8'h07, 8'h7F, 2'd3);
        send(8'hB1); send(8'h08); send(8'h70);
        check("ovr.pulse", {31'd0, overrun}, 32'd1);
        check_msg("held2", 8'hB0, 8'h07, 8'h7F, 2'd3);
        @(posedge clk); #1;
        check("ovr.once", {31'd0, overrun}, 32'd0);
        @(negedge clk);
        msg_ready = 1'b1;
        @(posedge clk); #1;
        check("accept", {31'd0, msg_valid}, 32'd0);

        // Reset mid-message with rdy held high across release
        send(8'h90); send(8'h3C);
        @(negedge clk);
        reset       = 1'b0;
        rx_data     = 8'h64;
        rx_data_rdy = 1'b1;
        @(posedge clk); #1;
        check("mrst.valid", {31'd0, msg_valid}, 32'd0);
        check("mrst.len",   {30'd0, msg_len}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("mrst.nocap", {31'd0, msg_valid}, 32'd0);
        send(8'h3C);
        check("mrst.d1", {31'd0, msg_valid}, 32'd0);
        send(8'h3C);
        check("mrst.d2", {31'd0, msg_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
